// File: rtl/red_seq_unit.sv
// -----------------------------------------------------------------------------
// red_seq_unit
//   Multi-cycle signed byte-reduction unit. Adds the four signed bytes of two
//   16-bit operands (A[7:0], A[15:8], B[7:0], B[15:8]) one byte per clock
//   through a single 10-bit accumulator and returns the sign-extended total.
//
//   Handshake: start is sampled in IDLE or DONE. Four accumulate cycles follow
//   (busy=1). The last one writes Sum/Error and raises done for one cycle.
//
//   Build option:
//     RED_SATURATE_EN  - clamp the result to -128..127, flag clamping on Error.
//                        When undefined, Sum is the full 10-bit result
//                        sign-extended and Error is tied to 0.
//
// Ports
//   clk    in   1   rising-edge clock
//   rst_n  in   1   asynchronous active-low reset
//   start  in   1   operation request
//   A      in  16   operand A (two signed bytes)
//   B      in  16   operand B (two signed bytes)
//   Sum    out 16   registered result, held until the next result
//   Error  out  1   saturation flag, registered with Sum
//   busy   out  1   high while accumulating
//   done   out  1   one-cycle pulse when Sum/Error become valid
// -----------------------------------------------------------------------------
module red_seq_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] A,
   input  logic [15:0] B,
   output logic [15:0] Sum,
   output logic        Error,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic        [31:0] ops_q, ops_d;    // {B, A} captured on the start edge
   logic signed [9:0]  acc_q, acc_d;
   logic        [1:0]  cnt_q, cnt_d;
   logic        [15:0] sum_q, sum_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic        [7:0]  byte_sel;
   logic signed [9:0]  acc_sum;
   logic        [15:0] result;
   logic               result_err;

   // Byte order 0..3 is A lo, A hi, B lo, B hi, which is exactly the
   // little-endian layout of {B, A}.
   assign byte_sel = ops_q[{cnt_q, 3'b000} +: 8];
   assign acc_sum  = acc_q + {{2{byte_sel[7]}}, byte_sel};

`ifdef RED_SATURATE_EN
   always_comb begin
      result     = {{6{acc_sum[9]}}, acc_sum};
      result_err = 1'b0;
      if (acc_sum > 10'sd127) begin
         result     = 16'h007F;
         result_err = 1'b1;
      end else if (acc_sum < -10'sd128) begin
         result     = 16'hFF80;
         result_err = 1'b1;
      end
   end
`else
   // Four signed bytes span -512..508, so the 10-bit total is exact.
   assign result     = {{6{acc_sum[9]}}, acc_sum};
   assign result_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      ops_d   = ops_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      err_d   = err_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
            if (start) begin
               ops_d   = {B, A};
               acc_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_ACC;
            end
         end
         S_ACC: begin
            // start is deliberately not looked at here: requests during
            // accumulation are dropped, not queued.
            acc_d = acc_sum;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               sum_d   = result;
               err_d   = result_err;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ops_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         sum_q   <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ops_q   <= ops_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign Sum   = sum_q;
   assign Error = err_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_red_seq_unit.sv
module tb_red_seq_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] A, B;
   logic [15:0] Sum;
   logic        Error, busy, done;

   int n_cmp = 0;
   int n_bad = 0;

   red_seq_unit dut (
      .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
      .Sum(Sum), .Error(Error), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Reference: plain integer sum of the four signed bytes, then the
   // build-dependent clamp.
   function automatic void ref_model(input logic [15:0] a, input logic [15:0] b,
                                     output logic [15:0] s, output logic e);
      int t;
      t = int'($signed(a[7:0])) + int'($signed(a[15:8]))
        + int'($signed(b[7:0])) + int'($signed(b[15:8]));
      e = 1'b0;
`ifdef RED_SATURATE_EN
      if (t > 127) begin t = 127; e = 1'b1; end
      else if (t < -128) begin t = -128; e = 1'b1; end
`endif
      s = 16'(t);
   endfunction

   // Reset values, then the first start right at release and a full operation.
   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
      #3;
      n_cmp++; if (Sum !== 16'h0000) begin n_bad++; $display("FAIL reset_sum: got %h want 0000", Sum); end
      n_cmp++; if ({Error, busy, done} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {Error, busy, done}); end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1; start = 1'b1; A = 16'h0102; B = 16'h03FC;
      @(posedge clk); #1;
      n_cmp++; if ({busy, done} !== 2'b10) begin n_bad++; $display("FAIL first_start: busy/done got %b want 10", {busy, done}); end
      @(negedge clk); start = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         n_cmp++; if ({busy, done} !== 2'b10) begin n_bad++; $display("FAIL first_acc%0d: busy/done got %b want 10", k, {busy, done}); end
      end
      @(posedge clk); #1;
      n_cmp++; if ({busy, done} !== 2'b01) begin n_bad++; $display("FAIL first_done: busy/done got %b want 01", {busy, done}); end
      n_cmp++; if (Sum !== 16'h0002 || Error !== 1'b0) begin n_bad++; $display("FAIL first_sum: got %h/%b want 0002/0", Sum, Error); end
      @(posedge clk); #1;
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL first_done_pulse: done got %b want 0", done); end
   endtask

   // Directed corner vectors followed by random operands; operands are
   // scrambled right after the latch edge to show they are not re-read.
   task automatic test_ops();
      logic [15:0] va[$];
      logic [15:0] vb[$];
      va = '{16'h7F7F, 16'h8080, 16'h0102, 16'h0000, 16'hFFFF, 16'h807F};
      vb = '{16'h7F7F, 16'h8080, 16'h03FC, 16'h0000, 16'h0101, 16'h7F80};
      for (int i = 0; i < 40; i++) begin
         va.push_back(16'($urandom));
         vb.push_back(16'($urandom));
      end
      for (int i = 0; i < va.size(); i++) begin
         logic [15:0] es;
         logic        ee;
         ref_model(va[i], vb[i], es, ee);
         @(negedge clk); A = va[i]; B = vb[i]; start = 1'b1;
         @(posedge clk); #1;
         n_cmp++; if ({busy, done} !== 2'b10) begin n_bad++; $display("FAIL op%0d_latch: busy/done got %b want 10", i, {busy, done}); end
         @(negedge clk); start = 1'b0; A = 16'($urandom); B = 16'($urandom);
         for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            n_cmp++; if ({busy, done} !== 2'b10) begin n_bad++; $display("FAIL op%0d_acc%0d: busy/done got %b want 10", i, k, {busy, done}); end
         end
         @(posedge clk); #1;
         n_cmp++; if ({busy, done} !== 2'b01) begin n_bad++; $display("FAIL op%0d_done: busy/done got %b want 01", i, {busy, done}); end
         n_cmp++; if (Sum !== es) begin n_bad++; $display("FAIL op%0d_sum: A=%h B=%h got %h want %h", i, va[i], vb[i], Sum, es); end
         n_cmp++; if (Error !== ee) begin n_bad++; $display("FAIL op%0d_err: A=%h B=%h got %b want %b", i, va[i], vb[i], Error, ee); end
         @(posedge clk); #1;
         n_cmp++; if (done !== 1'b0 || Sum !== es) begin n_bad++; $display("FAIL op%0d_hold: done/sum got %b/%h want 0/%h", i, done, Sum, es); end
      end
   endtask

   // start held high: results every 5 cycles, start during ACC ignored.
   task automatic test_back_to_back();
      @(negedge clk); A = 16'h0101; B = 16'h0000; start = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_latch: busy got %b want 1", busy); end
      for (int k = 1; k <= 10; k++) begin
         logic exp_done;
         @(negedge clk);
         if (k == 2) A = 16'h0202;
         if (k == 6) A = 16'hFFFF;
         if (k == 10) start = 1'b0;
         @(posedge clk); #1;
         exp_done = (k == 4 || k == 9);
         n_cmp++; if (done !== exp_done) begin n_bad++; $display("FAIL b2b_done_c%0d: got %b want %b", k, done, exp_done); end
         if (k >= 4 && k <= 8) begin
            n_cmp++; if (Sum !== 16'h0002) begin n_bad++; $display("FAIL b2b_sum1_c%0d: got %h want 0002", k, Sum); end
         end
         if (k >= 9) begin
            n_cmp++; if (Sum !== 16'h0004) begin n_bad++; $display("FAIL b2b_sum2_c%0d: got %h want 0004", k, Sum); end
         end
      end
      @(posedge clk); #1;
      n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL b2b_idle: busy/done got %b want 00", {busy, done}); end
   endtask

   // Reset in the middle of accumulation aborts it with no done pulse.
   task automatic test_reset_mid_acc();
      @(negedge clk); A = 16'h7F7F; B = 16'h7F7F; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (Sum !== 16'h0000) begin n_bad++; $display("FAIL mid_rst_sum: got %h want 0000", Sum); end
      n_cmp++; if ({busy, done, Error} !== 3'b000) begin n_bad++; $display("FAIL mid_rst_flags: got %b want 000", {busy, done, Error}); end
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         n_cmp++; if ({busy, done} !== 2'b00 || Sum !== 16'h0000) begin n_bad++; $display("FAIL mid_rst_quiet%0d: busy/done/sum got %b/%h want 00/0000", k, {busy, done}, Sum); end
      end
      @(negedge clk); A = 16'h0102; B = 16'h03FC; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         n_cmp++; if (done !== (k == 4)) begin n_bad++; $display("FAIL mid_rst_next_done%0d: got %b want %b", k, done, (k == 4)); end
      end
      n_cmp++; if (Sum !== 16'h0002 || Error !== 1'b0) begin n_bad++; $display("FAIL mid_rst_next_sum: got %h/%b want 0002/0", Sum, Error); end
   endtask

   initial begin
      test_reset();
      test_ops();
      test_back_to_back();
      test_reset_mid_acc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/red_seq_unit.md
# red_seq_unit

Multi-cycle signed byte-reduction unit for the compute datapath: the reducing counterpart to the parallel sub-word adder. The PSA splits operands into independent lanes; this block collapses both 16-bit operands into one sign-extended scalar, `sum(A bytes) + sum(B bytes)`. It sits beside the ALU in the execute stage and serves the RED instruction. It uses a start/busy/done handshake and accumulates one byte per clock so it can share a single 8-bit-in adder path.

## Interface
- No parameters; widths fixed (16-bit operands, 4 signed bytes per operation).
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- A  input  16  operand A; two signed bytes A[7:0], A[15:8].
- B  input  16  operand B; two signed bytes B[7:0], B[15:8].
- Sum  output  16  registered result; held until the next result is written.
- Error  output  1  saturation flag; registered with Sum.
- busy  output  1  high in ACC.
- done  output  1  one-cycle pulse in DONE; Sum/Error valid from this cycle on.

## Operation
- States: IDLE, ACC, DONE.
- IDLE:
  - start=1 → latch A and B into internal operand registers; clear accumulator (10-bit signed) and 2-bit byte counter; go to ACC.
  - start=0 → stay in IDLE.
- ACC: each cycle add sign-extended byte[cnt] to the accumulator.
  - Byte order: cnt 0 = A[7:0], 1 = A[15:8], 2 = B[7:0], 3 = B[15:8].
  - cnt=3 → write the final result to Sum/Error; go to DONE.
- DONE: done=1 for exactly one cycle.
  - start=1 → latch new operands and go to ACC (back-to-back).
  - start=0 → go to IDLE.
- start in ACC is ignored; it is not queued.
- A/B changes after the latch edge have no effect on the operation in flight.
- Arithmetic:
  - Accumulator is 10-bit signed; range −512..508, so it never overflows internally.
  - The result is the accumulator sign-extended to 16 bits.
- Sum and Error change only on the ACC→DONE edge.

## Timing
- Reset (asynchronous, any state): state=IDLE, Sum=16'h0000, Error=0, busy=0, done=0, cnt=0, accumulator=0.
- Reset mid-ACC aborts the operation. No done pulse is issued, and Sum returns to 0.
- Timeline for start sampled at edge E:
  - busy is high from E through E+4.
  - Accumulate edges are E+1..E+4; the fourth one (E+4) writes Sum/Error and enters DONE.
  - done is high from E+4 to E+5.
- Latency: 4 cycles from the start-sample edge to the edge that writes Sum.
- Throughput: one result per 5 cycles with start held high continuously (DONE→ACC).
- Deassertion of rst_n must meet recovery time relative to clk; the first start is accepted on the first edge after release.

## Configuration
- RED_SATURATE_EN defined:
  - The final result is clamped to the signed 8-bit range −128..127, then sign-extended to 16 bits.
  - Error=1 when clamping occurred, otherwise 0.
- RED_SATURATE_EN undefined:
  - Sum is the full 10-bit result sign-extended to 16 bits.
  - Error is tied to 0.
- Handshake and latency are identical in both builds.

## Test plan
- Reset, then A=16'h0102, B=16'h03FC, start pulse → done on the 4th edge after the sample edge; Sum=16'h0002, Error=0 (both builds).
- A=B=16'h7F7F → Sum=16'h01FC, Error=0 (undefined); Sum=16'h007F, Error=1 (RED_SATURATE_EN).
- A=B=16'h8080 → Sum=16'hFE00, Error=0 (undefined); Sum=16'hFF80, Error=1 (RED_SATURATE_EN).
- start held high, A=16'h0101 then A=16'h0202 with B=0 → done pulses 5 cycles apart; Sum=16'h0002 then 16'h0004. A changes inside ACC are ignored, and start pulses during ACC produce no extra done.
- rst_n asserted at the 2nd ACC cycle → immediately Sum=0, busy=0, done=0; no done pulse follows; next start completes normally.
